// File: rtl/arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : arb_pkg                                                      |
// | Brief  : Shared types and width constants for the round-robin arbiter |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
package arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 16;

  // Width of a binary field able to hold 0..value-1, never narrower than 1 bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int IDX_W = clog2_min1(N_REQ_DEF);
  localparam int CNT_W = clog2_min1(MAX_HOLD_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/idx_to_onehot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : idx_to_onehot                                                |
// | Brief  : Binary index to one-hot decoder covering all N_REQ codes     |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module idx_to_onehot
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [clog2_min1(N_REQ)-1:0] i_idx,
  output logic [N_REQ-1:0]             o_onehot
);

  localparam int SEL_W = clog2_min1(N_REQ);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
    assign o_onehot[gi] = (i_idx == SEL_W'(gi));
  end

endmodule
`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : rr_onehot_arbiter                                            |
// | Brief  : Round-robin arbiter, one-hot grant, hold limit with timeout  |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic                          done,
  output logic [N_REQ-1:0]              grant_onehot,
  output logic [clog2_min1(N_REQ)-1:0]  grant_idx,
  output logic                          grant_valid,
  output logic                          timeout
);

  localparam int GIDX_W = clog2_min1(N_REQ);
  localparam int HOLD_W = clog2_min1(MAX_HOLD);

  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
  localparam logic [GIDX_W-1:0] c_last_rst  = GIDX_W'(N_REQ - 1);

  arb_state_e          r_state;
  logic [GIDX_W-1:0]   r_idx;
  logic [GIDX_W-1:0]   r_last_idx;
  logic [N_REQ-1:0]    r_onehot;
  logic                r_valid;
  logic                r_timeout;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic [2*N_REQ-1:0]  w_req_dbl;
  logic [N_REQ-1:0]    w_req_rot;
  logic [GIDX_W-1:0]   w_start;
  logic [GIDX_W-1:0]   w_offset;
  logic [GIDX_W-1:0]   w_win_idx;
  logic [N_REQ-1:0]    w_win_onehot;
  logic                w_owner_req;
  logic                w_at_limit;
  logic                w_release;
  logic                w_limit_only;

  // Rotate requests so the scan start sits at bit 0; N_REQ is a power of two,
  // so adding the offset back wraps naturally in GIDX_W bits.
  assign w_start   = r_last_idx + 1'b1;
  assign w_req_dbl = {req, req};
  assign w_req_rot = w_req_dbl[w_start +: N_REQ];

  always_comb begin
    w_offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_offset = GIDX_W'(k);
      end
    end
  end

  assign w_win_idx = w_start + w_offset;

  idx_to_onehot #(
    .N_REQ (N_REQ)
  ) u_dec (
    .i_idx    (w_win_idx),
    .o_onehot (w_win_onehot)
  );

  assign w_owner_req  = req[r_idx];
  assign w_at_limit   = (r_hold_cnt == c_hold_last);
  assign w_release    = done | ~w_owner_req | w_at_limit;
  assign w_limit_only = w_at_limit & ~done & w_owner_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_last_idx <= c_last_rst;
      r_onehot   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state    <= GRANT;
            r_idx      <= w_win_idx;
            r_onehot   <= w_win_onehot;
            r_valid    <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state    <= GAP;
            r_last_idx <= r_idx;
            r_onehot   <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= w_limit_only;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant_onehot = r_onehot;
  assign grant_idx    = r_idx;
  assign grant_valid  = r_valid;
  assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_rr_onehot_arbiter                                         |
// | Brief  : Directed and random checks against a cycle-level owner model |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_rr_onehot_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant_onehot;
  logic [1:0]   grant_idx;
  logic         grant_valid;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the resource, for how many cycles so far.
  int m_owner  = -1;
  int m_last   = N - 1;
  int m_cycles = 0;
  bit m_gap    = 1'b0;
  bit m_to     = 1'b0;

  bit prev_valid = 1'b0;
  int starts[$];

  always #5 clk = ~clk;

  rr_onehot_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_cycles = 0;
    m_gap    = 1'b0;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input bit d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_cycles == HOLD) begin
        m_to    = !d && r[m_owner];
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_cycles++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (r != '0) begin
      for (int off = 1; off <= N; off++) begin
        int cand;
        cand = (m_last + off) % N;
        if (r[cand] && m_owner < 0) begin
          m_owner  = cand;
          m_cycles = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    if (m_owner >= 0) exp_oh[m_owner] = 1'b1;
    check_val("grant_valid", grant_valid, (m_owner >= 0));
    check_val("grant_onehot", grant_onehot, exp_oh);
    if (m_owner >= 0) check_val("grant_idx", grant_idx, m_owner);
    check_val("timeout", timeout, m_to);
    if (grant_valid && !prev_valid) starts.push_back(int'(grant_idx));
    prev_valid = grant_valid;
  endtask

  task automatic step(input logic [N-1:0] r, input bit d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cnt;
    int           held;
    bit           seen;
    bit           coincided;
    bit           d;
    logic [N-1:0] r;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_val("rst_idx", grant_idx, 0);

    // Quiet after reset.
    repeat (5) step('0, 1'b0);

    // All requesting, done on the second grant cycle.
    starts.delete();
    cnt = 0;
    while (starts.size() < 5 && cnt < 100) begin
      step(4'b1111, (m_owner >= 0 && m_cycles == 2));
      cnt++;
    end
    check_val("rr_bound", (starts.size() >= 5), 1);
    if (starts.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_val("rr_seq", starts[i], i % N);
    end

    // Single requester holds to the limit.
    cnt  = 0;
    held = 0;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      step(4'b0100, 1'b0);
      if (grant_onehot == 4'b0100) held++;
      if (timeout) seen = 1'b1;
      cnt++;
    end
    check_val("limit_timeout_seen", seen, 1);
    check_val("limit_hold_len", held, HOLD);
    step(4'b0100, 1'b0);
    check_val("idle_after_gap", grant_valid, 0);
    step(4'b0100, 1'b0);
    check_val("regrant_valid", grant_valid, 1);
    check_val("regrant_idx", grant_idx, 2);

    // Owner 1 drops its request mid-grant.
    cnt = 0;
    while (m_owner != 1 && cnt < 60) begin
      step(4'b1010, (m_owner >= 0 && m_cycles == 2));
      cnt++;
    end
    check_val("owner1_bound", (m_owner == 1), 1);
    starts.delete();
    step(4'b1000, 1'b0);
    check_val("drop_release", grant_valid, 0);
    check_val("drop_no_timeout", timeout, 0);
    cnt = 0;
    while (starts.size() == 0 && cnt < 10) begin
      step(4'b1010, 1'b0);
      cnt++;
    end
    check_val("drop_next_bound", (starts.size() > 0), 1);
    if (starts.size() > 0) check_val("drop_next_idx", starts[0], 3);

    // done coincides with the hold limit.
    seen      = 1'b0;
    coincided = 1'b0;
    repeat (30) begin
      d = (m_owner == 0 && m_cycles == HOLD);
      if (d) coincided = 1'b1;
      step(4'b0001, d);
      if (timeout) seen = 1'b1;
    end
    check_val("coincide_reached", coincided, 1);
    check_val("coincide_no_timeout", seen, 0);

    // Asynchronous reset during a grant.
    cnt = 0;
    while (m_owner < 0 && cnt < 10) begin
      step(4'b1110, 1'b0);
      cnt++;
    end
    check_val("pre_rst_grant", grant_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_onehot", grant_onehot, 0);
    check_val("async_rst_valid", grant_valid, 0);
    check_val("async_rst_timeout", timeout, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    compare_all();
    step(4'b0110, 1'b0);
    check_val("post_rst_valid", grant_valid, 1);
    check_val("post_rst_idx", grant_idx, 1);

    // Random traffic.
    r = 4'b0110;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) r = N'($urandom_range(15));
      step(r, ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
